// File: rtl/sahb_slave_mux_if.sv
// Shrinked-AHB bus bundle between one CPU master, the slave mux and its N slaves.
// The slave modport is the mux view; the master modport is the CPU/slave-model view.
interface sahb_slave_mux_if #(
    parameter int NSLV = 3,
    parameter int AW   = 32
);
    logic [AW-1:0]     haddr;
    logic              htrans;
    logic              hwrite;
    logic              hburst;
    logic [7:0]        hwdata;
    logic [7:0]        hrdata;
    logic              hready;
    logic              hresp;
    logic [NSLV-1:0]   hsel_s;
    logic [NSLV*8-1:0] hrdata_s;
    logic [NSLV-1:0]   hready_s;
    logic [NSLV-1:0]   hresp_s;
    logic              err_valid;
    logic [AW-1:0]     err_addr;
    logic [1:0]        err_code;
    logic              err_clr;
    logic              err_irq;

    modport slave (
        input  haddr, htrans, hwrite, hburst, hwdata,
        input  hrdata_s, hready_s, hresp_s, err_clr,
        output hrdata, hready, hresp, hsel_s,
        output err_valid, err_addr, err_code, err_irq
    );

    modport master (
        output haddr, htrans, hwrite, hburst, hwdata,
        output hrdata_s, hready_s, hresp_s, err_clr,
        input  hrdata, hready, hresp, hsel_s,
        input  err_valid, err_addr, err_code, err_irq
    );
endinterface

// File: rtl/sahb_slave_mux.sv
// One-master to N-slave shrinked-AHB mux with region decode, default ERROR slave,
// data-phase watchdog and sticky first-error capture.
module sahb_slave_mux #(
    parameter int                   NSLV      = 3,
    parameter int                   AW        = 32,
    parameter logic [NSLV*AW-1:0]   SLV_BASE  = {32'h00C0_0500, 32'h0000_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0]   SLV_MASK  = {32'h00FF_0F00, 32'h0000_0000, 32'h0000_0000},
    parameter logic [NSLV-1:0]      ZERO_WAIT = 3'b100,
    parameter int                   TIMEOUT   = 255
) (
    input  logic               hclk,
    input  logic               hreset_n,
    sahb_slave_mux_if.slave    bus
);
    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic [IW-1:0]   slv_reg, slv_next;
    logic [WW-1:0]   wcnt_reg, wcnt_next;
    logic [AW-1:0]   aphase_addr_reg;
    logic            err_valid_reg;
    logic [AW-1:0]   err_addr_reg;
    logic [1:0]      err_code_reg;
    logic            err_irq_reg;

    logic [NSLV-1:0] match;
    logic            hit;
    logic [IW-1:0]   win_idx;
    logic [7:0]      slv_rdata;
    logic            slv_ready, slv_resp;
    logic            hready_int, hresp_int;
    logic [7:0]      hrdata_int;
    logic            accept, wait_cyc, timeout;
    logic            miss_err, slv_err, new_err;
    logic [1:0]      new_code;
    logic [AW-1:0]   new_addr;
    logic            unused_ok;

    // Write-side qualifiers go straight from the master to every slave.
    assign unused_ok = ^{bus.hwrite, bus.hburst, bus.hwdata};

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_dec
            assign match[gi] = ((bus.haddr ^ SLV_BASE[gi*AW +: AW]) & SLV_MASK[gi*AW +: AW]) == '0;
            assign bus.hsel_s[gi] = bus.htrans & hit & (win_idx == IW'(gi));
        end
    endgenerate

    // Scan downwards so the lowest matching slave is the last one written.
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        for (int k = NSLV - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit     = 1'b1;
                win_idx = IW'(k);
            end
        end
    end

    assign slv_rdata = bus.hrdata_s[slv_reg*8 +: 8];
    assign slv_ready = bus.hready_s[slv_reg] | ZERO_WAIT[slv_reg];
    assign slv_resp  = bus.hresp_s[slv_reg];

    always_comb begin
        hready_int = 1'b1;
        hresp_int  = 1'b0;
        hrdata_int = 8'h00;
        case (state_reg)
            ST_DATA: begin
                hready_int = slv_ready;
                hresp_int  = slv_resp;
                hrdata_int = slv_rdata;
            end
            ST_ERR1: begin
                hready_int = 1'b0;
                hresp_int  = 1'b1;
            end
            ST_ERR2: begin
                hready_int = 1'b1;
                hresp_int  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.hready = hready_int;
    assign bus.hresp  = hresp_int;
    assign bus.hrdata = hrdata_int;

    assign accept   = hready_int & bus.htrans;
    assign wait_cyc = (state_reg == ST_DATA) & ~slv_ready;
    // Fires on the TIMEOUT-th wait cycle, so the master sees exactly TIMEOUT waits before ERR1.
    assign timeout  = wait_cyc & (TIMEOUT != 0) &
                      (({1'b0, wcnt_reg} + 1'b1) == (WW+1)'(TIMEOUT));

    always_comb begin
        state_next = state_reg;
        slv_next   = slv_reg;
        wcnt_next  = wcnt_reg;
        if (timeout) begin
            state_next = ST_ERR1;
        end else if (state_reg == ST_ERR1) begin
            state_next = ST_ERR2;
        end else if (hready_int) begin
            if (accept && hit) begin
                state_next = ST_DATA;
                slv_next   = win_idx;
                wcnt_next  = '0;
            end else if (accept) begin
                state_next = ST_ERR1;
            end else begin
                state_next = ST_IDLE;
            end
        end else if (wait_cyc) begin
            wcnt_next = wcnt_reg + 1'b1;
        end
    end

    assign miss_err = accept & ~hit;
    assign slv_err  = (state_reg == ST_DATA) & slv_ready & slv_resp;
    assign new_err  = miss_err | slv_err | timeout;

    // A completing data-phase error predates a miss accepted in the same cycle.
    always_comb begin
        new_code = 2'b01;
        new_addr = bus.haddr;
        if (slv_err) begin
            new_code = 2'b10;
            new_addr = aphase_addr_reg;
        end else if (timeout) begin
            new_code = 2'b11;
            new_addr = aphase_addr_reg;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_reg       <= ST_IDLE;
            slv_reg         <= '0;
            wcnt_reg        <= '0;
            aphase_addr_reg <= '0;
            err_valid_reg   <= 1'b0;
            err_addr_reg    <= '0;
            err_code_reg    <= 2'b00;
            err_irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            slv_reg     <= slv_next;
            wcnt_reg    <= wcnt_next;
            err_irq_reg <= new_err;
            if (accept) begin
                aphase_addr_reg <= bus.haddr;
            end
            if (new_err) begin
                if (!err_valid_reg || bus.err_clr) begin
                    err_valid_reg <= 1'b1;
                    err_addr_reg  <= new_addr;
                    err_code_reg  <= new_code;
                end
            end else if (bus.err_clr) begin
                err_valid_reg <= 1'b0;
                err_code_reg  <= 2'b00;
            end
        end
    end

    assign bus.err_valid = err_valid_reg;
    assign bus.err_addr  = err_addr_reg;
    assign bus.err_code  = err_code_reg;
    assign bus.err_irq   = err_irq_reg;
endmodule

// File: tb/tb_sahb_slave_mux.sv
// Directed bench for sahb_slave_mux: zero-wait read, wait states, timeout,
// decode misses with sticky capture, pipelined transfers, async reset, slave ERROR.
module tb_sahb_slave_mux;
    localparam int NSLV = 3;
    localparam int AW   = 32;
    localparam int TO   = 255;
    localparam logic [NSLV*AW-1:0] TB_BASE = {32'h00C0_0500, 32'h0020_0000, 32'h0010_0000};
    localparam logic [NSLV*AW-1:0] TB_MASK = {32'h00FF_0F00, 32'hFFF0_0000, 32'hFFF0_0000};

    logic hclk;
    logic hreset_n;
    int   n_assert;
    int   n_fail;
    int   waits;
    bit   done;

    sahb_slave_mux_if #(.NSLV(NSLV), .AW(AW)) bus ();

    sahb_slave_mux #(
        .NSLV(NSLV), .AW(AW), .SLV_BASE(TB_BASE), .SLV_MASK(TB_MASK),
        .ZERO_WAIT(3'b100), .TIMEOUT(TO)
    ) dut (
        .hclk(hclk),
        .hreset_n(hreset_n),
        .bus(bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no end of test, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        hreset_n = 1'b0;
        bus.haddr    = '0;
        bus.htrans   = 1'b0;
        bus.hwrite   = 1'b0;
        bus.hburst   = 1'b0;
        bus.hwdata   = 8'h00;
        bus.hrdata_s = {8'h5A, 8'h11, 8'h22};
        bus.hready_s = 3'b111;
        bus.hresp_s  = 3'b000;
        bus.err_clr  = 1'b0;

        // Reset state
        #1;
        chk("rst_hready", bus.hready, 1);
        chk("rst_hresp", bus.hresp, 0);
        chk("rst_hrdata", bus.hrdata, 0);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_err_addr", bus.err_addr, 0);
        chk("rst_err_irq", bus.err_irq, 0);
        bus.htrans = 1'b1;
        bus.haddr  = 32'h00C0_0512;
        settle();
        chk("rst_hsel_comb", bus.hsel_s, 3'b100);
        bus.htrans = 1'b0;
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();
        $display("reset released");

        // Zero-wait read from slave 2 even with its hready_s low
        bus.hready_s[2] = 1'b0;
        bus.htrans = 1'b1;
        bus.haddr  = 32'h00C0_0512;
        settle();
        chk("zw_hsel", bus.hsel_s, 3'b100);
        chk("zw_aphase_hready", bus.hready, 1);
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("zw_hready", bus.hready, 1);
        chk("zw_hrdata", bus.hrdata, 8'h5A);
        chk("zw_hresp", bus.hresp, 0);
        chk("zw_hsel_idle", bus.hsel_s, 3'b000);
        tick();
        bus.hready_s[2] = 1'b1;
        $display("read slave2 addr 00c00512 done");

        // Write to slave 0 with 3 wait states
        bus.hready_s[0] = 1'b0;
        bus.htrans = 1'b1;
        bus.hwrite = 1'b1;
        bus.hwdata = 8'hC3;
        bus.haddr  = 32'h0010_0000;
        settle();
        chk("wr_hsel", bus.hsel_s, 3'b001);
        tick();
        bus.htrans = 1'b0;
        bus.hwrite = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wr_wait_hready", bus.hready, 0);
            chk("wr_wait_hresp", bus.hresp, 0);
            tick();
        end
        bus.hready_s[0] = 1'b1;
        settle();
        chk("wr_done_hready", bus.hready, 1);
        tick();
        chk("wr_err_valid", bus.err_valid, 0);
        $display("write slave0 addr 00100000 done");

        // Slave 0 never ready: watchdog abort
        bus.hready_s[0] = 1'b0;
        bus.htrans = 1'b1;
        bus.haddr  = 32'h0012_3456;
        tick();
        bus.htrans = 1'b0;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            settle();
            if (bus.hready == 1'b0 && bus.hresp == 1'b0) begin
                waits++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        chk("to_wait_count", 64'(waits), 64'(TO));
        chk("to_err1_hready", bus.hready, 0);
        chk("to_err1_hresp", bus.hresp, 1);
        chk("to_err_irq", bus.err_irq, 1);
        chk("to_err_valid", bus.err_valid, 1);
        chk("to_err_code", bus.err_code, 2'b11);
        chk("to_err_addr", bus.err_addr, 32'h0012_3456);
        tick();
        chk("to_err2_hready", bus.hready, 1);
        chk("to_err2_hresp", bus.hresp, 1);
        chk("to_irq_single", bus.err_irq, 0);
        tick();
        bus.hready_s[0] = 1'b1;
        $display("timeout slave0 addr 00123456 done, %0d waits", waits);

        // Clear the captured error
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        settle();
        chk("clr_err_valid", bus.err_valid, 0);
        chk("clr_err_code", bus.err_code, 0);

        // First decode miss
        bus.htrans = 1'b1;
        bus.haddr  = 32'hFF00_0000;
        settle();
        chk("miss1_hsel", bus.hsel_s, 3'b000);
        chk("miss1_aphase_hready", bus.hready, 1);
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("miss1_err1_hready", bus.hready, 0);
        chk("miss1_err1_hresp", bus.hresp, 1);
        chk("miss1_irq", bus.err_irq, 1);
        chk("miss1_err_code", bus.err_code, 2'b01);
        chk("miss1_err_addr", bus.err_addr, 32'hFF00_0000);
        tick();
        chk("miss1_err2_hready", bus.hready, 1);
        chk("miss1_err2_hresp", bus.hresp, 1);
        tick();
        chk("miss1_idle_hresp", bus.hresp, 0);
        $display("miss addr ff000000 done");

        // Second miss: irq only, first error kept
        bus.htrans = 1'b1;
        bus.haddr  = 32'hFF00_0004;
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("miss2_irq", bus.err_irq, 1);
        chk("miss2_err_addr_kept", bus.err_addr, 32'hFF00_0000);
        chk("miss2_err_code", bus.err_code, 2'b01);
        tick();
        tick();
        $display("miss addr ff000004 done");

        // Third miss with err_clr in the same cycle: new error is loaded
        bus.err_clr = 1'b1;
        bus.htrans  = 1'b1;
        bus.haddr   = 32'hFF00_0008;
        tick();
        bus.err_clr = 1'b0;
        bus.htrans  = 1'b0;
        settle();
        chk("miss3_err_valid", bus.err_valid, 1);
        chk("miss3_err_addr", bus.err_addr, 32'hFF00_0008);
        chk("miss3_err_code", bus.err_code, 2'b01);
        chk("miss3_irq", bus.err_irq, 1);
        tick();
        tick();
        $display("miss addr ff000008 with clear done");

        // Back-to-back: slave 1 (one wait) then slave 2
        bus.hready_s[1] = 1'b0;
        bus.htrans = 1'b1;
        bus.haddr  = 32'h0020_0010;
        settle();
        chk("b2b_hsel1", bus.hsel_s, 3'b010);
        tick();
        bus.haddr = 32'h00C0_0500;
        settle();
        chk("b2b_wait_hready", bus.hready, 0);
        chk("b2b_hsel2_held", bus.hsel_s, 3'b100);
        tick();
        bus.hready_s[1] = 1'b1;
        settle();
        chk("b2b_s1_hready", bus.hready, 1);
        chk("b2b_s1_hrdata", bus.hrdata, 8'h11);
        chk("b2b_hsel2", bus.hsel_s, 3'b100);
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("b2b_s2_hready", bus.hready, 1);
        chk("b2b_s2_hrdata", bus.hrdata, 8'h5A);
        tick();
        $display("back-to-back slave1/slave2 done");

        // Asynchronous reset during ERR1
        bus.htrans = 1'b1;
        bus.haddr  = 32'hFF00_00F0;
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("arst_pre_hresp", bus.hresp, 1);
        hreset_n = 1'b0;
        #1;
        chk("arst_hready", bus.hready, 1);
        chk("arst_hresp", bus.hresp, 0);
        chk("arst_err_valid", bus.err_valid, 0);
        chk("arst_err_code", bus.err_code, 0);
        chk("arst_err_addr", bus.err_addr, 0);
        chk("arst_err_irq", bus.err_irq, 0);
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();
        bus.htrans = 1'b1;
        bus.haddr  = 32'h0010_0004;
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("post_rst_hready", bus.hready, 1);
        chk("post_rst_hrdata", bus.hrdata, 8'h22);
        chk("post_rst_hresp", bus.hresp, 0);
        tick();
        chk("post_rst_err_valid", bus.err_valid, 0);
        $display("reset during ERR1 then read slave0 done");

        // Slave ERROR passed through and captured
        bus.hresp_s[1] = 1'b1;
        bus.htrans = 1'b1;
        bus.haddr  = 32'h0020_0000;
        tick();
        bus.htrans = 1'b0;
        settle();
        chk("serr_hresp", bus.hresp, 1);
        chk("serr_hready", bus.hready, 1);
        tick();
        bus.hresp_s[1] = 1'b0;
        settle();
        chk("serr_err_valid", bus.err_valid, 1);
        chk("serr_err_code", bus.err_code, 2'b10);
        chk("serr_err_addr", bus.err_addr, 32'h0020_0000);
        chk("serr_irq", bus.err_irq, 1);
        tick();
        $display("slave1 error response done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
